// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sequencer: state encoding,
// settle-counter width and the vector-count helper.
package tts_pkg;

  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Number of input combinations for an n-input function
  function automatic int unsigned NUM_VEC(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Loadable down-counter with a zero flag; times how long stim is held
// before the implementation outputs are sampled.
module tts_settle_timer
  import tts_pkg::*;
#(
  parameter int unsigned W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Clocked exhaustive-sweep controller: drives every input combination in
// ascending order, waits a settle interval, samples all implementation
// outputs, flags disagreement with the golden output (bit 0) and captures
// the golden truth table.
// Optional build macro STOP_ON_FAIL_EN: end the sweep at the first
// vector that shows any mismatch.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int unsigned NUM_IN     = 3,
  parameter int unsigned NUM_OUT    = 6,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic [NUM_IN-1:0]             stim,
  input  logic [NUM_OUT-1:0]            dut_out,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [NUM_OUT-1:0]            mism_mask,
  output logic                          fail_valid,
  output logic [NUM_IN-1:0]             fail_vec,
  output logic [NUM_VEC(NUM_IN)-1:0]    truth_table
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [NUM_IN-1:0]   LAST_VEC    = '1;

  state_t             state;
  logic               timer_load;
  logic               timer_dec;
  logic               timer_zero;
  logic [NUM_OUT-1:0] cur_mism;
  logic               stop_now;

  // Every output compared against the golden bit; bit 0 is zero by construction
  assign cur_mism   = dut_out ^ {NUM_OUT{dut_out[0]}};
  assign timer_load = (state == DRIVE);
  assign timer_dec  = (state == SETTLE);

`ifdef STOP_ON_FAIL_EN
  assign stop_now = (stim == LAST_VEC) || (|cur_mism);
`else
  assign stop_now = (stim == LAST_VEC);
`endif

  tts_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Sweep FSM with registered status and capture outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stim        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b1;
      mism_mask   <= '0;
      fail_valid  <= 1'b0;
      fail_vec    <= '0;
      truth_table <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= DRIVE;
            stim        <= '0;
            busy        <= 1'b1;
            mism_mask   <= '0;
            fail_valid  <= 1'b0;
            fail_vec    <= '0;
            truth_table <= '0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            truth_table[stim] <= dut_out[0];
            mism_mask         <= mism_mask | cur_mism;
            if ((|cur_mism) && !fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= stim;
            end
            // Terminal check precedes the increment so stim never wraps
            if (stop_now) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= ~(|(mism_mask | cur_mism));
            end else begin
              stim  <= stim + 1'b1;
              state <= DRIVE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer. Implementation outputs are
// produced from a per-vector pattern table; expectations come from a
// behavioural sweep model over that table.
module tb_truth_table_sequencer;

  localparam int NUM_IN     = 3;
  localparam int NUM_OUT    = 6;
  localparam int SETTLE_CYC = 2;
  localparam int NV         = 1 << NUM_IN;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [NUM_IN-1:0]  stim;
  logic [NUM_OUT-1:0] dut_out;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_OUT-1:0] mism_mask;
  logic               fail_valid;
  logic [NUM_IN-1:0]  fail_vec;
  logic [NV-1:0]      truth_table;

  logic [NUM_OUT-1:0] pat [NV];

  int errors = 0;
  int checks = 0;

  logic [NV-1:0]      exp_tt;
  logic [NUM_OUT-1:0] exp_mask;
  logic               exp_fv;
  logic [NUM_IN-1:0]  exp_fvec;
  logic               exp_pass;
  int                 exp_cyc;

  truth_table_sequencer #(
    .NUM_IN     (NUM_IN),
    .NUM_OUT    (NUM_OUT),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .stim        (stim),
    .dut_out     (dut_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .mism_mask   (mism_mask),
    .fail_valid  (fail_valid),
    .fail_vec    (fail_vec),
    .truth_table (truth_table)
  );

  always #5 clk = ~clk;

  // Implementations respond combinationally to stim
  always_comb dut_out = pat[stim];

  // Golden function F = X&Y | Z with X = stim[2], Y = stim[1], Z = stim[0]
  function automatic logic golden_f(input int v);
    int x, y, z;
    x = (v / 4) % 2;
    y = (v / 2) % 2;
    z = v % 2;
    return ((x == 1 && y == 1) || z == 1) ? 1'b1 : 1'b0;
  endfunction

  task automatic set_golden();
    for (int i = 0; i < NV; i++) pat[i] = golden_f(i) ? '1 : '0;
  endtask

  // Sweep model over the first lim vectors of pat
  task automatic model(input int lim);
    bit stopped;
    exp_tt = '0; exp_mask = '0; exp_fv = 1'b0; exp_fvec = '0; exp_cyc = 1;
    stopped = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (!stopped) begin
        logic g;
        bit any;
        g = pat[i][0];
        exp_tt[i] = g;
        exp_cyc += 2 + SETTLE_CYC;
        any = 1'b0;
        for (int b = 0; b < NUM_OUT; b++) begin
          if (pat[i][b] != g) begin
            exp_mask[b] = 1'b1;
            any = 1'b1;
          end
        end
        if (any && !exp_fv) begin
          exp_fv = 1'b1;
          exp_fvec = NUM_IN'(i);
        end
`ifdef STOP_ON_FAIL_EN
        if (any) stopped = 1'b1;
`endif
      end
    end
    exp_pass = (exp_mask == '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stim !== '0) begin errors++; $display("FAIL reset_stim: got %0d want 0", stim); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL reset_pass: got %b want 1", pass); end
    checks++; if (mism_mask !== '0) begin errors++; $display("FAIL reset_mask: got %b want 0", mism_mask); end
    checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", fail_valid); end
    checks++; if (fail_vec !== '0) begin errors++; $display("FAIL reset_fvec: got %0d want 0", fail_vec); end
    checks++; if (truth_table !== '0) begin errors++; $display("FAIL reset_tt: got %b want 0", truth_table); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full sweep from a start pulse, compared against the model
  task automatic test_sweep(input string name, input bit spam);
    int n;
    model(NV);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1 at cycle %0d", name, busy, n); end
      if (spam) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++; if (n != exp_cyc) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, n, exp_cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", name, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b want 0", name, busy); end
    checks++; if (pass !== exp_pass) begin errors++; $display("FAIL %s_pass: got %b want %b", name, pass, exp_pass); end
    checks++; if (mism_mask !== exp_mask) begin errors++; $display("FAIL %s_mask: got %b want %b", name, mism_mask, exp_mask); end
    checks++; if (fail_valid !== exp_fv) begin errors++; $display("FAIL %s_fv: got %b want %b", name, fail_valid, exp_fv); end
    checks++; if (fail_vec !== exp_fvec) begin errors++; $display("FAIL %s_fvec: got %0d want %0d", name, fail_vec, exp_fvec); end
    checks++; if (truth_table !== exp_tt) begin errors++; $display("FAIL %s_tt: got %b want %b", name, truth_table, exp_tt); end
    checks++; if (stim !== 3'(exp_cyc / (2 + SETTLE_CYC) - 1)) begin
      errors++; $display("FAIL %s_stim_hold: got %0d want %0d", name, stim, exp_cyc / (2 + SETTLE_CYC) - 1);
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b want 0", name, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy: got %b want 0", name, busy); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_golden();
    set_golden();
    test_sweep("golden", 1'b0);
  endtask

  task automatic test_single_fault();
    set_golden();
    pat[5][3] = ~pat[5][3];
    test_sweep("single_fault", 1'b0);
  endtask

  task automatic test_two_faults();
    set_golden();
    pat[2][1] = ~pat[2][1];
    pat[6][4] = ~pat[6][4];
    test_sweep("two_faults", 1'b0);
  endtask

  task automatic test_start_ignored_and_reset();
    int n;
    set_golden();
    pat[1][2] = ~pat[1][2];
    test_sweep("start_spam", 1'b1);
    set_golden();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (stim !== 3'd4 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (stim !== 3'd4) begin errors++; $display("FAIL rst_reach_stim4: got %0d want 4", stim); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (stim !== '0) begin errors++; $display("FAIL rst_mid_stim: got %0d want 0", stim); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rst_mid_pass: got %b want 1", pass); end
    checks++; if (truth_table !== '0) begin errors++; $display("FAIL rst_mid_tt: got %b want 0", truth_table); end
    checks++; if ({mism_mask, fail_valid, fail_vec} !== '0) begin
      errors++; $display("FAIL rst_mid_fail: got mask=%b fv=%b fvec=%0d want all 0", mism_mask, fail_valid, fail_vec);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid_quiet: got done=%b busy=%b want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_abort();
    int n;
    logic prev_pass;
    set_golden();
    prev_pass = pass;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (stim !== 3'd3 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (stim !== 3'd3) begin errors++; $display("FAIL abort_reach_stim3: got %0d want 3", stim); end
    @(posedge clk); #1;          // now in the settle interval of vector 3
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    model(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (truth_table !== exp_tt) begin errors++; $display("FAIL abort_tt: got %b want %b", truth_table, exp_tt); end
    checks++; if (pass !== prev_pass) begin errors++; $display("FAIL abort_pass: got %b want %b", pass, prev_pass); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done); end
    end
    test_sweep("after_abort", 1'b0);
  endtask

  task automatic test_random();
    logic [NV-1:0] g;
    for (int r = 0; r < 12; r++) begin
      g = NV'($urandom);
      for (int i = 0; i < NV; i++) begin
        pat[i] = g[i] ? '1 : '0;
        if ($urandom_range(0, 3) == 0) pat[i] = pat[i] ^ NUM_OUT'($urandom_range(1, (1 << NUM_OUT) - 1));
      end
      test_sweep("random", ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    set_golden();
    test_reset();
    test_golden();
    test_single_fault();
    test_two_faults();
    test_start_ignored_and_reset();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
